// File: rtl/pipe_pkg.sv
// Shared decode/execute definitions: register-index sizing, control-vector
// field positions, RV32 opcodes and the decode/execute payload layout.
package pipe_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_COUNT_DEF = 32;
  localparam int CTRL_SIZE_DEF = 21;

  // Number of index bits needed to address a register file of 'count' entries
  function automatic int reg_bits(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  localparam int REG_BITS_DEF = reg_bits(REG_COUNT_DEF);

  // Control vector field positions
  localparam int CTRL_MEMREAD    = 0;
  localparam int CTRL_MEMWRITE   = 1;
  localparam int CTRL_REGWRITE   = 2;
  localparam int CTRL_MEMTOREG   = 3;
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_JAL        = 5;
  localparam int CTRL_JALR       = 6;
  localparam int CTRL_ALUSRC     = 7;
  localparam int CTRL_LUI        = 8;
  localparam int CTRL_AUIPC      = 9;
  localparam int CTRL_ALUOP_LSB  = 10;  // 4-bit ALU operation class
  localparam int CTRL_FUNCT3_LSB = 14;  // 3-bit funct3 copy
  localparam int CTRL_F7B5       = 17;  // instr[30]
  localparam int CTRL_ILLEGAL    = 18;
  localparam int CTRL_RS1_USED   = 19;
  localparam int CTRL_RS2_USED   = 20;
  localparam int CTRL_BASE_BITS  = 21;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Decode/execute payload so the execute stage can unpack by field name
  typedef struct packed {
    logic [REG_BITS_DEF-1:0]  rs1;
    logic [REG_BITS_DEF-1:0]  rs2;
    logic [REG_BITS_DEF-1:0]  rd;
    logic [CTRL_SIZE_DEF-1:0] ctrl;
    logic [XLEN_DEF-1:0]      rdata1;
    logic [XLEN_DEF-1:0]      rdata2;
    logic [XLEN_DEF-1:0]      imm;
    logic [31:0]              pc;
  } decex_payload_t;

endpackage

// File: rtl/controller.sv
// Main decoder: turns the opcode/funct fields into the control vector
// consumed by execute, memory and writeback.
module controller
  import pipe_pkg::*;
#(
  parameter int CTRL_SIZE = CTRL_SIZE_DEF
) (
  input  logic [31:0]          i_instr,
  output logic [CTRL_SIZE-1:0] o_ctrl
);

  logic [CTRL_BASE_BITS-1:0] w_ctrl;

  // Decode opcode into control flags; unknown opcodes raise the illegal flag
  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_FUNCT3_LSB +: 3] = i_instr[14:12];
    w_ctrl[CTRL_F7B5]            = i_instr[30];
    case (i_instr[6:0])
      OPC_LOAD: begin
        w_ctrl[CTRL_MEMREAD]  = 1'b1;
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_MEMTOREG] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_ctrl[CTRL_RS1_USED] = 1'b1;
      end
      OPC_STORE: begin
        w_ctrl[CTRL_MEMWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_ctrl[CTRL_RS1_USED] = 1'b1;
        w_ctrl[CTRL_RS2_USED] = 1'b1;
      end
      OPC_OPIMM: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_ctrl[CTRL_RS1_USED] = 1'b1;
        w_ctrl[CTRL_ALUOP_LSB +: 4] = 4'd1;
      end
      OPC_OP: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_RS1_USED] = 1'b1;
        w_ctrl[CTRL_RS2_USED] = 1'b1;
        w_ctrl[CTRL_ALUOP_LSB +: 4] = 4'd2;
      end
      OPC_BRANCH: begin
        w_ctrl[CTRL_BRANCH]   = 1'b1;
        w_ctrl[CTRL_RS1_USED] = 1'b1;
        w_ctrl[CTRL_RS2_USED] = 1'b1;
        w_ctrl[CTRL_ALUOP_LSB +: 4] = 4'd3;
      end
      OPC_LUI: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_LUI]      = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_ctrl[CTRL_ALUOP_LSB +: 4] = 4'd4;
      end
      OPC_AUIPC: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_AUIPC]    = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_ctrl[CTRL_ALUOP_LSB +: 4] = 4'd5;
      end
      OPC_JAL: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_JAL]      = 1'b1;
        w_ctrl[CTRL_ALUOP_LSB +: 4] = 4'd6;
      end
      OPC_JALR: begin
        w_ctrl[CTRL_REGWRITE] = 1'b1;
        w_ctrl[CTRL_JALR]     = 1'b1;
        w_ctrl[CTRL_ALUSRC]   = 1'b1;
        w_ctrl[CTRL_RS1_USED] = 1'b1;
        w_ctrl[CTRL_ALUOP_LSB +: 4] = 4'd6;
      end
      default: begin
        w_ctrl[CTRL_ILLEGAL] = 1'b1;
      end
    endcase
  end

  assign o_ctrl = CTRL_SIZE'(w_ctrl);

endmodule

// File: rtl/immgen.sv
// Immediate generator: extracts and sign-extends the RV32I immediate
// selected by the opcode; formats without an immediate produce zero.
module immgen
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  // Select the immediate layout from the major opcode
  always_comb begin
    w_imm32 = 32'd0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR:
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      OPC_STORE:
        w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPC_BRANCH:
        w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm32 = {i_instr[31:12], 12'd0};
      OPC_JAL:
        w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
      default:
        w_imm32 = 32'd0;
    endcase
  end

  assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, hard-wired zero register and optional same-cycle write bypass.
module regfile_bypass
  import pipe_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int WB_BYPASS = 1,
  localparam int REG_BITS = reg_bits(REG_COUNT)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_wb_en,
  input  logic [REG_BITS-1:0] i_wb_rd,
  input  logic [XLEN-1:0]     i_wb_data,
  input  logic [REG_BITS-1:0] i_rs1,
  input  logic [REG_BITS-1:0] i_rs2,
  output logic [XLEN-1:0]     o_rdata1,
  output logic [XLEN-1:0]     o_rdata2
);

  logic [XLEN-1:0] r_regs [REG_COUNT];
  logic            w_wr;

  assign w_wr = i_wb_en && (i_wb_rd != '0) && (int'(i_wb_rd) < REG_COUNT);

  // Register storage: cleared on reset, written on the clock edge when enabled
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end else begin
      r_regs[i_wb_rd] <= r_regs[i_wb_rd];
    end
  end

  // Read ports: x0 and out-of-range read zero; a matching writeback wins when bypassing
  always_comb begin
    o_rdata1 = '0;
    o_rdata2 = '0;
    if ((i_rs1 == '0) || (int'(i_rs1) >= REG_COUNT)) begin
      o_rdata1 = '0;
    end else if ((WB_BYPASS != 0) && w_wr && (i_wb_rd == i_rs1)) begin
      o_rdata1 = i_wb_data;
    end else begin
      o_rdata1 = r_regs[i_rs1];
    end
    if ((i_rs2 == '0) || (int'(i_rs2) >= REG_COUNT)) begin
      o_rdata2 = '0;
    end else if ((WB_BYPASS != 0) && w_wr && (i_wb_rd == i_rs2)) begin
      o_rdata2 = i_wb_data;
    end else begin
      o_rdata2 = r_regs[i_rs2];
    end
  end

endmodule

// File: rtl/decode_stage_hs.sv
// Decode pipeline stage with valid/ready handshakes, load-use bubble
// insertion, flush, register-file bypass and a saturating stall counter.
module decode_stage_hs
  import pipe_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int REG_COUNT   = REG_COUNT_DEF,
  parameter int CTRL_SIZE   = CTRL_SIZE_DEF,
  parameter int MEMREAD_BIT = CTRL_MEMREAD,
  parameter int WB_BYPASS   = 1,
  localparam int REG_BITS   = reg_bits(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 if_valid,
  output logic                 if_ready,
  input  logic [31:0]          if_instr,
  input  logic [31:0]          if_pc,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [REG_BITS-1:0]  wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 ex_ready,
  output logic                 ex_valid,
  output logic [REG_BITS-1:0]  ex_rs1,
  output logic [REG_BITS-1:0]  ex_rs2,
  output logic [REG_BITS-1:0]  ex_rd,
  output logic [CTRL_SIZE-1:0] ex_ctrl,
  output logic [XLEN-1:0]      ex_rdata1,
  output logic [XLEN-1:0]      ex_rdata2,
  output logic [XLEN-1:0]      ex_imm,
  output logic [31:0]          ex_pc,
  output logic [31:0]          stall_cnt
);

  logic [REG_BITS-1:0]  w_rs1, w_rs2, w_rd;
  logic [CTRL_SIZE-1:0] w_ctrl;
  logic [XLEN-1:0]      w_rdata1, w_rdata2, w_imm;
  logic                 w_adv, w_haz, w_stall_evt;

  logic                 r_ex_valid;
  logic [REG_BITS-1:0]  r_rs1, r_rs2, r_rd;
  logic [CTRL_SIZE-1:0] r_ctrl;
  logic [XLEN-1:0]      r_rdata1, r_rdata2, r_imm;
  logic [31:0]          r_pc;
  logic [31:0]          r_stall_cnt;

  assign w_rs1 = if_instr[15 +: REG_BITS];
  assign w_rs2 = if_instr[20 +: REG_BITS];
  assign w_rd  = if_instr[7  +: REG_BITS];

  controller #(.CTRL_SIZE(CTRL_SIZE)) u_controller (
    .i_instr (if_instr),
    .o_ctrl  (w_ctrl)
  );

  immgen #(.XLEN(XLEN)) u_immgen (
    .i_instr (if_instr),
    .o_imm   (w_imm)
  );

  regfile_bypass #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT),
    .WB_BYPASS (WB_BYPASS)
  ) u_regfile (
    .clk       (clk),
    .rstn      (rstn),
    .i_wb_en   (wb_en),
    .i_wb_rd   (wb_rd),
    .i_wb_data (wb_data),
    .i_rs1     (w_rs1),
    .i_rs2     (w_rs2),
    .o_rdata1  (w_rdata1),
    .o_rdata2  (w_rdata2)
  );

  // The output register can take a new entry when empty or being drained.
  // A load in the output register whose destination feeds either source
  // field of the incoming word forces one bubble, whatever the format.
  assign w_adv       = ~r_ex_valid | ex_ready;
  assign w_haz       = r_ex_valid & r_ctrl[MEMREAD_BIT] & (r_rd != '0) &
                       ((r_rd == w_rs1) | (r_rd == w_rs2));
  assign w_stall_evt = if_valid & w_adv & w_haz & ~flush;
  assign if_ready    = w_adv & ~w_haz & ~flush;

  // Output register: flush beats bubble beats load beats drain; else hold
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ex_valid <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_pc       <= 32'd0;
    end else if (flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_adv && if_valid && w_haz) begin
      r_ex_valid <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_imm      <= '0;
      r_pc       <= 32'd0;
    end else if (w_adv && if_valid) begin
      r_ex_valid <= 1'b1;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_ctrl     <= w_ctrl;
      r_rdata1   <= w_rdata1;
      r_rdata2   <= w_rdata2;
      r_imm      <= w_imm;
      r_pc       <= if_pc;
    end else if (w_adv) begin
      r_ex_valid <= 1'b0;
    end else begin
      r_ex_valid <= r_ex_valid;
    end
  end

  // Load-use stall counter, saturating at all-ones
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign ex_valid  = r_ex_valid;
  assign ex_rs1    = r_rs1;
  assign ex_rs2    = r_rs2;
  assign ex_rd     = r_rd;
  assign ex_ctrl   = r_ctrl;
  assign ex_rdata1 = r_rdata1;
  assign ex_rdata2 = r_rdata2;
  assign ex_imm    = r_imm;
  assign ex_pc     = r_pc;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Bench for decode_stage_hs: directed scenarios plus randomized traffic,
// checked against a cycle-level reference model of the stage's rules.
module tb_decode_stage_hs;

  logic        clk, rstn, if_valid, flush, wb_en, ex_ready;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_rd;

  logic        if_ready, ex_valid;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [20:0] ex_ctrl;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc, stall_cnt;

  logic        nb_if_ready, nb_ex_valid;
  logic [4:0]  nb_rs1, nb_rs2, nb_rd;
  logic [20:0] nb_ctrl;
  logic [31:0] nb_rdata1, nb_rdata2, nb_imm, nb_pc, nb_stall;

  decode_stage_hs #(.WB_BYPASS(1)) dut (
    .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .stall_cnt(stall_cnt)
  );

  decode_stage_hs #(.WB_BYPASS(0)) dut_nb (
    .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_ready(nb_if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush), .wb_en(wb_en),
    .wb_rd(wb_rd), .wb_data(wb_data), .ex_ready(ex_ready), .ex_valid(nb_ex_valid),
    .ex_rs1(nb_rs1), .ex_rs2(nb_rs2), .ex_rd(nb_rd), .ex_ctrl(nb_ctrl),
    .ex_rdata1(nb_rdata1), .ex_rdata2(nb_rdata2), .ex_imm(nb_imm),
    .ex_pc(nb_pc), .stall_cnt(nb_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_valid, m_load;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_rd1, m_rd2, m_rd1_nb, m_rd2_nb, m_imm, m_pc, m_stall;
  logic        s_if_ready;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0; m_load = 1'b0;
    m_rs1 = 5'd0; m_rs2 = 5'd0; m_rd = 5'd0;
    m_rd1 = 32'd0; m_rd2 = 32'd0; m_rd1_nb = 32'd0; m_rd2_nb = 32'd0;
    m_imm = 32'd0; m_pc = 32'd0; m_stall = 32'd0;
  endtask

  // Value seen by a read port: x0 is zero; a same-cycle write is visible only when bypassing
  function automatic logic [31:0] ref_read(input bit bypass, input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (bypass && wb_en && (wb_rd == idx)) return wb_data;
    return m_regs[idx];
  endfunction

  // Immediate value by instruction format, computed arithmetically
  function automatic logic [31:0] imm_of(input logic [31:0] w);
    int v;
    v = 0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        v = int'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
      7'b0100011: begin
        v = int'(w[31:25]) * 32 + int'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        v = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'b0110111, 7'b0010111: v = int'(w[31:12]) * 4096;
      7'b1101111: begin
        v = int'(w[31]) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  // One clock cycle with the currently driven inputs; checks both DUTs against the model
  task automatic step();
    logic [4:0] rs1, rs2, rd;
    logic adv, haz, exp_rdy;
    logic n_valid, n_load;
    logic [4:0] n_rs1, n_rs2, n_rd;
    logic [31:0] n_rd1, n_rd2, n_rd1_nb, n_rd2_nb, n_imm, n_pc, n_stall;
    logic do_wr;
    logic [4:0] wr_idx;
    logic [31:0] wr_val;

    @(negedge clk);
    rs1 = if_instr[19:15];
    rs2 = if_instr[24:20];
    rd  = if_instr[11:7];
    adv = !m_valid || ex_ready;
    haz = m_valid && m_load && (m_rd != 5'd0) && ((m_rd == rs1) || (m_rd == rs2));
    exp_rdy = adv && !haz && !flush;
    s_if_ready = if_ready;
    check_val("if_ready", {31'd0, if_ready}, {31'd0, exp_rdy});
    check_val("nb_if_ready", {31'd0, nb_if_ready}, {31'd0, exp_rdy});

    n_valid = m_valid; n_load = m_load; n_rs1 = m_rs1; n_rs2 = m_rs2; n_rd = m_rd;
    n_rd1 = m_rd1; n_rd2 = m_rd2; n_rd1_nb = m_rd1_nb; n_rd2_nb = m_rd2_nb;
    n_imm = m_imm; n_pc = m_pc; n_stall = m_stall;

    if (flush) begin
      n_valid = 1'b0;
    end else if (adv && if_valid && haz) begin
      n_valid = 1'b0; n_load = 1'b0; n_rs1 = 5'd0; n_rs2 = 5'd0; n_rd = 5'd0;
      n_rd1 = 32'd0; n_rd2 = 32'd0; n_rd1_nb = 32'd0; n_rd2_nb = 32'd0;
      n_imm = 32'd0; n_pc = 32'd0;
    end else if (adv && if_valid) begin
      n_valid = 1'b1;
      n_load = (if_instr[6:0] == 7'b0000011);
      n_rs1 = rs1; n_rs2 = rs2; n_rd = rd;
      n_rd1 = ref_read(1'b1, rs1); n_rd2 = ref_read(1'b1, rs2);
      n_rd1_nb = ref_read(1'b0, rs1); n_rd2_nb = ref_read(1'b0, rs2);
      n_imm = imm_of(if_instr);
      n_pc = if_pc;
    end else if (adv) begin
      n_valid = 1'b0;
    end
    if (if_valid && adv && haz && !flush && (m_stall != 32'hFFFF_FFFF)) n_stall = m_stall + 32'd1;

    do_wr = wb_en && (wb_rd != 5'd0);
    wr_idx = wb_rd;
    wr_val = wb_data;

    @(posedge clk);
    #1;
    if (do_wr) m_regs[wr_idx] = wr_val;
    m_valid = n_valid; m_load = n_load; m_rs1 = n_rs1; m_rs2 = n_rs2; m_rd = n_rd;
    m_rd1 = n_rd1; m_rd2 = n_rd2; m_rd1_nb = n_rd1_nb; m_rd2_nb = n_rd2_nb;
    m_imm = n_imm; m_pc = n_pc; m_stall = n_stall;

    check_val("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    check_val("ex_rs1", {27'd0, ex_rs1}, {27'd0, m_rs1});
    check_val("ex_rs2", {27'd0, ex_rs2}, {27'd0, m_rs2});
    check_val("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    check_val("ex_memread", {31'd0, ex_ctrl[0]}, {31'd0, m_load});
    check_val("ex_rdata1", ex_rdata1, m_rd1);
    check_val("ex_rdata2", ex_rdata2, m_rd2);
    check_val("ex_imm", ex_imm, m_imm);
    check_val("ex_pc", ex_pc, m_pc);
    check_val("stall_cnt", stall_cnt, m_stall);
    check_val("nb_ex_valid", {31'd0, nb_ex_valid}, {31'd0, m_valid});
    check_val("nb_rdata1", nb_rdata1, m_rd1_nb);
    check_val("nb_rdata2", nb_rdata2, m_rd2_nb);
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v; if_instr = instr; if_pc = pc;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [9];
    logic [31:0] w;
    opcs[0] = 7'b0000011; opcs[1] = 7'b0010011; opcs[2] = 7'b0110011;
    opcs[3] = 7'b0100011; opcs[4] = 7'b1100011; opcs[5] = 7'b0110111;
    opcs[6] = 7'b0010111; opcs[7] = 7'b1101111; opcs[8] = 7'b1100111;
    w = $urandom;
    w[6:0]   = opcs[$urandom_range(0, 8)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    return w;
  endfunction

  localparam logic [31:0] I_ADDI_X5 = {12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011};
  localparam logic [31:0] I_LW_X3   = {12'd0, 5'd1, 3'b010, 5'd3, 7'b0000011};
  localparam logic [31:0] I_ADD_X4  = {7'd0, 5'd2, 5'd3, 3'b000, 5'd4, 7'b0110011};
  localparam logic [31:0] I_LW_X0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] I_ADD_X40 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd4, 7'b0110011};
  localparam logic [31:0] I_ADDI_X9 = {12'd3, 5'd0, 3'b000, 5'd9, 7'b0010011};
  localparam logic [31:0] I_ADD_X7  = {7'd0, 5'd6, 5'd6, 3'b000, 5'd7, 7'b0110011};
  localparam logic [31:0] I_ADD_X8  = {7'd0, 5'd0, 5'd0, 3'b000, 5'd8, 7'b0110011};

  initial begin
    logic [31:0] stall_before;
    rstn = 1'b0; if_valid = 1'b0; if_instr = 32'd0; if_pc = 32'd0;
    flush = 1'b0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; ex_ready = 1'b1;
    model_reset();
    s_if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_val("rst_stall", stall_cnt, 32'd0);
    check_val("rst_pc", ex_pc, 32'd0);
    rstn = 1'b1;

    // Basic pass: addi x5,x0,7 at pc 0x10
    drive(1'b1, I_ADDI_X5, 32'h10);
    step();
    check_val("basic_valid", {31'd0, ex_valid}, 32'd1);
    check_val("basic_rd", {27'd0, ex_rd}, 32'd5);
    check_val("basic_imm", ex_imm, 32'd7);
    check_val("basic_pc", ex_pc, 32'h10);
    check_val("basic_rdata1", ex_rdata1, 32'd0);

    // Load-use: lw x3 then add x4,x3,x2 costs one bubble
    stall_before = m_stall;
    drive(1'b1, I_LW_X3, 32'h14);
    step();
    drive(1'b1, I_ADD_X4, 32'h18);
    step();
    check_val("lu_if_ready", {31'd0, s_if_ready}, 32'd0);
    check_val("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check_val("lu_stall", stall_cnt, stall_before + 32'd1);
    step();
    check_val("lu_add_issue", {31'd0, ex_valid}, 32'd1);
    check_val("lu_add_rd", {27'd0, ex_rd}, 32'd4);

    // lw x0 followed by a consumer of x0: no bubble
    drive(1'b1, I_LW_X0, 32'h1C);
    step();
    drive(1'b1, I_ADD_X40, 32'h20);
    step();
    check_val("x0_if_ready", {31'd0, s_if_ready}, 32'd1);
    check_val("x0_no_bubble", {31'd0, ex_valid}, 32'd1);

    // Backpressure: output holds for three cycles, next word follows ex_ready
    drive(1'b1, I_ADDI_X9, 32'h20);
    step();
    ex_ready = 1'b0;
    drive(1'b1, I_ADDI_X5, 32'h24);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("bp_if_ready", {31'd0, s_if_ready}, 32'd0);
      check_val("bp_pc_hold", ex_pc, 32'h20);
    end
    ex_ready = 1'b1;
    step();
    check_val("bp_next_pc", ex_pc, 32'h24);

    // Bypass: writeback of -5 to x6 while decoding add x7,x6,x6
    wb_en = 1'b1; wb_rd = 5'd6; wb_data = 32'hFFFF_FFFB;
    drive(1'b1, I_ADD_X7, 32'h28);
    step();
    check_val("byp_rdata1", ex_rdata1, 32'hFFFF_FFFB);
    check_val("byp_rdata2", ex_rdata2, 32'hFFFF_FFFB);
    check_val("nobyp_rdata1", nb_rdata1, 32'd0);
    wb_rd = 5'd0; wb_data = 32'd9;
    drive(1'b1, I_ADD_X8, 32'h2C);
    step();
    check_val("x0_write_ignored", ex_rdata1, 32'd0);
    wb_en = 1'b0;
    drive(1'b1, I_ADD_X7, 32'h30);
    step();
    check_val("x6_written", nb_rdata2, 32'hFFFF_FFFB);

    // Flush beats a pending load-use hazard
    drive(1'b1, I_LW_X3, 32'h34);
    step();
    stall_before = m_stall;
    flush = 1'b1;
    drive(1'b1, I_ADD_X4, 32'h38);
    step();
    check_val("fl_if_ready", {31'd0, s_if_ready}, 32'd0);
    check_val("fl_valid", {31'd0, ex_valid}, 32'd0);
    check_val("fl_stall", stall_cnt, stall_before);
    flush = 1'b0;
    step();
    check_val("fl_after_valid", {31'd0, ex_valid}, 32'd1);
    check_val("fl_after_pc", ex_pc, 32'h38);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = rand_instr();
      if_pc    = $urandom & 32'hFFFF_FFFC;
      flush    = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      wb_en    = ($urandom_range(0, 1) != 0);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      step();
    end

    // Reset in the middle of traffic with a held instruction at pc 0x40
    flush = 1'b0; wb_en = 1'b0; ex_ready = 1'b1;
    drive(1'b1, I_LW_X3, 32'h3C);
    step();
    drive(1'b1, I_ADD_X4, 32'h40);
    step();
    step();
    ex_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    step();
    check_val("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    check_val("pre_rst_pc", ex_pc, 32'h40);
    #2;
    rstn = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
    check_val("mid_rst_pc", ex_pc, 32'd0);
    check_val("mid_rst_rd", {27'd0, ex_rd}, 32'd0);
    check_val("mid_rst_ctrl", {11'd0, ex_ctrl}, 32'd0);
    check_val("mid_rst_imm", ex_imm, 32'd0);
    check_val("mid_rst_rdata", ex_rdata1 | ex_rdata2, 32'd0);
    check_val("mid_rst_stall", stall_cnt, 32'd0);
    model_reset();
    rstn = 1'b1;
    ex_ready = 1'b1;
    drive(1'b1, I_ADD_X7, 32'h44);
    step();
    check_val("rst_regfile_cleared", nb_rdata1, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
